// File: rtl/rv_fwd_sel_ctrl.sv
// Operand-forwarding controller for the RISC-V overlay pipeline.
// Tracks destination registers of the instructions in EX, MEM and WB.
// For each instruction leaving ID it produces registered select values for
// the two EX-stage operand muxes, and stalls ID on load-use hazards.
module rv_fwd_sel_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  id_alt1,
    input  logic                  id_alt2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_we,
    input  logic                  id_is_load,
    input  logic                  flush,
    output logic                  ex_valid,
    output logic [2:0]            ex_sel1,
    output logic [2:0]            ex_sel2,
    output logic [CNT_W-1:0]      stall_cnt
);

    // Mux select encoding as seen by the consumer once it sits in EX.
    localparam logic [2:0] SEL_RF   = 3'd0;
    localparam logic [2:0] SEL_MEM  = 3'd1;
    localparam logic [2:0] SEL_WB   = 3'd2;
    localparam logic [2:0] SEL_RET  = 3'd3;
    localparam logic [2:0] SEL_ALT  = 3'd4;

    // Tracking entries; bit/index 0 = EX, 1 = MEM, 2 = WB.
    logic [2:0]                  st_valid_reg;
    logic [2:0]                  st_we_reg;
    logic [2:0]                  st_load_reg;
    logic [REG_ADDR_W-1:0]       st_rd_reg [3];

    logic                        ex_valid_reg;
    logic [2:0]                  ex_sel1_reg;
    logic [2:0]                  ex_sel2_reg;
    logic [CNT_W-1:0]            stall_cnt_reg;

    // Per-operand views of the ID fields so both operands share one generate body.
    logic [REG_ADDR_W-1:0]       rs_vec   [2];
    logic                        used_vec [2];
    logic                        alt_vec  [2];
    logic [2:0]                  match    [2];
    logic                        hazard   [2];
    logic [2:0]                  sel_next [2];

    logic                        issue;
    logic                        stall;

    assign rs_vec[0]   = id_rs1;
    assign rs_vec[1]   = id_rs2;
    assign used_vec[0] = id_rs1_used;
    assign used_vec[1] = id_rs2_used;
    assign alt_vec[0]  = id_alt1;
    assign alt_vec[1]  = id_alt2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic rs_nonzero;
            assign rs_nonzero = (rs_vec[gi] != '0);

            // A stage matches when it will write the source register; x0 never matches.
            assign match[gi] = st_valid_reg & st_we_reg & {3{rs_nonzero}} &
                               {(st_rd_reg[2] == rs_vec[gi]),
                                (st_rd_reg[1] == rs_vec[gi]),
                                (st_rd_reg[0] == rs_vec[gi])};

            // Load data is not yet forwardable while the load sits in EX or MEM.
            assign hazard[gi] = used_vec[gi] & ~alt_vec[gi] &
                                (|(match[gi][1:0] & st_load_reg[1:0]));

            // Priority chain: youngest producer wins.
            assign sel_next[gi] = alt_vec[gi]   ? SEL_ALT :
                                  !used_vec[gi] ? SEL_RF  :
                                  match[gi][0]  ? SEL_MEM :
                                  match[gi][1]  ? SEL_WB  :
                                  match[gi][2]  ? SEL_RET : SEL_RF;
        end
    endgenerate

    assign id_ready = ~id_valid | ~(hazard[0] | hazard[1]);
    assign issue    = id_valid & id_ready & ~flush;
    assign stall    = id_valid & ~id_ready;

    // Shift the tracking entries and load EX with the issued instruction or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_valid_reg <= '0;
            st_we_reg    <= '0;
            st_load_reg  <= '0;
            for (int i = 0; i < 3; i++) st_rd_reg[i] <= '0;
        end else begin
            st_valid_reg <= {st_valid_reg[1:0], issue};
            st_we_reg    <= {st_we_reg[1:0], issue & id_rd_we};
            st_load_reg  <= {st_load_reg[1:0], issue & id_is_load};
            st_rd_reg[2] <= st_rd_reg[1];
            st_rd_reg[1] <= st_rd_reg[0];
            st_rd_reg[0] <= issue ? id_rd : '0;
        end
    end

    // Register the selects for the instruction entering EX; bubbles get register-file selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg <= 1'b0;
            ex_sel1_reg  <= SEL_RF;
            ex_sel2_reg  <= SEL_RF;
        end else begin
            ex_valid_reg <= issue;
            ex_sel1_reg  <= issue ? sel_next[0] : SEL_RF;
            ex_sel2_reg  <= issue ? sel_next[1] : SEL_RF;
        end
    end

    // Saturating count of cycles where ID holds a valid instruction but cannot advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign ex_valid  = ex_valid_reg;
    assign ex_sel1   = ex_sel1_reg;
    assign ex_sel2   = ex_sel2_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule
